rs_encoder: RTL and testbench
=============================

Name: rs_encoder

Overview:
Systematic Reed-Solomon encoder over GF(2^8): the transmit-side counterpart of the decoder chain (syndromes / Berlekamp-Massey / Chien / Forney).
- Streams k message symbols through unchanged, then appends NSYM parity symbols.
- Parity is computed by an LFSR division by the generator polynomial g(x).
- The field is selected by the shared reduction_matrix, so encoder and decoder always use the same GF configuration.

Parameters:
NSYM, 32, number of parity symbols (2*MAX_ERRORS); legal range 2..64
MAX_LEN, 255, maximum codeword length n = k + NSYM

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
reduction_matrix  in  57 ([7*8:0])  GF reduction matrix, same encoding as the decoder multipliers; static while busy
generator_flat  in  8*NSYM  g_0..g_(NSYM-1), g_i at bits [8*i+7:8*i]; g_NSYM=1 implied (monic); static while busy
msg_len  in  8  k, sampled on start
start  in  1  one-cycle request to begin a codeword
busy  out  1  high from accepted start until the last parity handshake
len_error  out  1  sticky; set on a start with illegal msg_len, cleared by the next legal start
in_data  in  8  message symbol
in_valid  in  1  in_data valid
in_ready  out  1  encoder accepts in_data this cycle
out_data  out  8  codeword symbol
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  qualifies the final parity symbol
done  out  1  one-cycle pulse in the cycle after the last parity handshake

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; parity regs r[0..NSYM-1]=0; symbol counter=0.
  - Outputs busy, len_error, in_ready, out_valid, out_last, done = 0; out_data = 0.
- States: IDLE -> DATA -> PARITY -> IDLE.
- IDLE:
  - start=1 with 1 <= msg_len <= MAX_LEN-NSYM: latch k, clear r[], counter=0, clear len_error, go to DATA, busy=1 next cycle.
  - Illegal msg_len: set len_error, stay in IDLE.
  - in_valid is ignored in IDLE.
- start outside IDLE is ignored; it does not abort the current codeword.
- Output register: a single stage. "Slot free" = !out_valid || out_ready.
- DATA:
  - in_ready = slot free.
  - On in_valid && in_ready:
    - fb = in_data ^ r[NSYM-1]
    - r[0] <= fb*g_0; r[i] <= r[i-1] ^ fb*g_i for i >= 1
    - out_data <= in_data; out_valid <= 1; counter++
  - When the k-th symbol is accepted, go to PARITY; counter resets to 0.
  - Latency: input accept to out_valid is 1 cycle. Throughput: 1 symbol/cycle while out_ready=1.
- PARITY:
  - in_ready = 0.
  - Whenever the slot is free, load out_data <= r[NSYM-1]; shift r[i] <= r[i-1], r[0] <= 0; set out_valid=1; counter++.
  - out_last = 1 with the NSYM-th parity symbol.
  - Parity order: highest degree first (r[NSYM-1] down to r[0]).
  - After the handshake of the out_last symbol: out_valid=0, busy=0, done pulses for 1 cycle, state=IDLE.
- Backpressure: out_valid && !out_ready holds out_data, out_last and r[] stable, and in_ready=0. No symbol is dropped or duplicated.
- Same cycle as the last data symbol is accepted: the first parity symbol is loaded on the next free slot, with no bubble when out_ready stays 1.
  - Total: k+NSYM output symbols in k+NSYM cycles under full throughput.
- Reset mid-codeword aborts immediately. No partial done.
- GF multiply: NSYM combinational multiplies by generator constants, sharing reduction_matrix. XOR is GF addition.

Optional Feature:
Macro RS_ENCODER_PARITY_FLAT_EN.
- Defined: adds output parity_flat [8*NSYM-1:0].
  - At the DATA->PARITY transition it captures r[], with r[i] at [8*i+7:8*i].
  - It holds until the next accepted start and resets to 0.
  - The parity serialization is unchanged.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - GF symbol width constant (8)
  - state enum (IDLE/DATA/PARITY)
  - reduction_matrix width constant (57)
  - default NSYM/MAX_LEN
- Sub-module rs_lfsr_cell: one 8-bit register, one constant-coefficient GF multiply (reusing finite_field_multiplier_mastravito), one XOR, and a shift/load mux. It is instantiated NSYM times.

Test Plan:
All cases use GF(2^8) poly 0x11D, NSYM=2, g=x^2+3x+2 (g_0=2, g_1=3), unless noted.
- k=1, in=[01], out_ready=1 -> out 01,03,02; out_last on 02; done 1 cycle later.
- k=2, in=[01,00] -> out 01,00,07,06; result checked against a software polynomial-division model.
- k=2, in=[00,00] -> out 00,00,00,00; out_last on the 4th symbol.
- Backpressure: k=2, in=[01,00], out_ready toggled 1,0,0,1,... -> same 01,00,07,06 sequence, each symbol held while stalled, no drops or duplicates.
- start with msg_len=0 and with msg_len=254 (>253) -> len_error=1, state IDLE, in_ready=0. Then a legal start -> len_error=0.
- NSYM=32, generator for first_root=0: random k=223 message encoded, fed to the decoder with 16 injected errors -> corrected data equals the original message. Also: rst pulled low mid-DATA -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rs_encoder_pkg.sv
// Purpose : shared constants and state type for the Reed-Solomon encoder slice.
// Latency : n/a (declarations only).
// Backpres: n/a.
// reduction_matrix encoding: row j (bits [8*j+7:8*j], j=0..6) holds x^(8+j) mod p(x);
// bit 56 is reserved and ignored by the multipliers.
package rs_encoder_pkg;

    localparam int SYM_W       = 8;              // GF(2^8) symbol width
    localparam int RED_W       = 7 * SYM_W + 1;  // reduction_matrix width (57)
    localparam int NSYM_DEF    = 32;
    localparam int MAX_LEN_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/finite_field_multiplier_mastravito.sv
// Purpose : combinational GF(2^8) multiply, Mastrovito style (carry-less product + matrix reduction).
// Latency : 0 cycles (pure combinational).
// Backpres: n/a.
// Ports   : a, b operands; reduction_matrix selects the field; y = a*b.
module finite_field_multiplier_mastravito
    import rs_encoder_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    input  logic [RED_W-1:0] reduction_matrix,
    output logic [SYM_W-1:0] y
);

    logic [2*SYM_W-2:0] prod;
    logic               unused_red_msb;

    // The top matrix bit carries no reduction row.
    assign unused_red_msb = reduction_matrix[RED_W-1];

    always_comb begin
        prod = '0;
        for (int i = 0; i < SYM_W; i++) begin
            for (int j = 0; j < SYM_W; j++) begin
                prod[i+j] = prod[i+j] ^ (a[i] & b[j]);
            end
        end
        // Fold each high-order term x^(8+j) back using its precomputed residue row.
        y = prod[SYM_W-1:0];
        for (int j = 0; j < SYM_W-1; j++) begin
            if (prod[SYM_W+j]) begin
                y = y ^ reduction_matrix[SYM_W*j +: SYM_W];
            end
        end
    end

endmodule

// File: rtl/rs_lfsr_cell.sv
// Purpose : one stage of the generator-division LFSR: register, constant multiply, XOR, shift/load mux.
// Latency : 1 cycle (register updates on the edge when feed/shift/clear is asserted).
// Backpres: holds its value whenever neither feed, shift nor clear is asserted.
// Ports   : coef = g_i, fb = feedback symbol, prev = r[i-1] (0 for stage 0), q = r[i].
module rs_lfsr_cell
    import rs_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [RED_W-1:0] reduction_matrix,
    input  logic [SYM_W-1:0] coef,
    input  logic [SYM_W-1:0] fb,
    input  logic [SYM_W-1:0] prev,
    input  logic             clear,
    input  logic             feed,
    input  logic             shift,
    output logic [SYM_W-1:0] q
`ifdef RS_ENCODER_PARITY_FLAT_EN
    ,
    output logic [SYM_W-1:0] nxt_feed
`endif
);

    logic [SYM_W-1:0] prod;
    logic [SYM_W-1:0] feed_val;

    finite_field_multiplier_mastravito u_mul (
        .a                (fb),
        .b                (coef),
        .reduction_matrix (reduction_matrix),
        .y                (prod)
    );

    assign feed_val = prev ^ prod;

`ifdef RS_ENCODER_PARITY_FLAT_EN
    assign nxt_feed = feed_val;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (feed) begin
            q <= feed_val;
        end else if (shift) begin
            q <= prev;
        end
    end

endmodule

// File: rtl/rs_encoder.sv
// Purpose : systematic RS encoder over GF(2^8): passes k message symbols, then appends NSYM parity symbols.
// Latency : 1 cycle input accept -> out_valid; 1 symbol/cycle, k+NSYM cycles per codeword at full rate.
// Backpres: single output register; in_ready drops and all state holds while out_valid && !out_ready.
// Optional: define RS_ENCODER_PARITY_FLAT_EN to add parity_flat (parallel parity snapshot).
// Ports   : clk/rst (async active-low); reduction_matrix, generator_flat static while busy;
//           start/msg_len/busy/len_error/done control; in_* and out_* valid-ready streams.
module rs_encoder
    import rs_encoder_pkg::*;
#(
    parameter int NSYM    = NSYM_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RED_W-1:0]      reduction_matrix,
    input  logic [SYM_W*NSYM-1:0] generator_flat,
    input  logic [7:0]            msg_len,
    input  logic                  start,
    output logic                  busy,
    output logic                  len_error,
    input  logic [SYM_W-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SYM_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
`ifdef RS_ENCODER_PARITY_FLAT_EN
    ,
    output logic [SYM_W*NSYM-1:0] parity_flat
`endif
);

    localparam logic [7:0] NSYM_L = 8'(NSYM);
    localparam logic [7:0] K_MAX  = 8'(MAX_LEN - NSYM);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       k_len;
    logic [7:0]       cnt;
    logic [SYM_W-1:0] r [NSYM];

    logic             slot_free;
    logic             start_ok;
    logic             lfsr_clear;
    logic             accept;
    logic             last_data;
    logic             par_load;
    logic             last_hs;
    logic [SYM_W-1:0] fb;

    assign slot_free  = !out_valid || out_ready;
    assign start_ok   = start && (msg_len != 8'd0) && (msg_len <= K_MAX);
    assign lfsr_clear = (state == IDLE) && start_ok;
    assign in_ready   = (state == DATA) && slot_free;
    assign accept     = in_valid && in_ready;
    assign last_data  = accept && (cnt == k_len - 8'd1);
    // cnt counts parity symbols already loaded; stop loading once all NSYM are out.
    assign par_load   = (state == PARITY) && slot_free && (cnt != NSYM_L);
    assign last_hs    = (state == PARITY) && out_valid && out_ready && out_last;
    assign fb         = in_data ^ r[NSYM-1];
    assign busy       = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)  state_nxt = DATA;
            DATA:    if (last_data) state_nxt = PARITY;
            PARITY:  if (last_hs)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // ---------------- control and output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len     <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            len_error <= 1'b0;
        end else begin
            done <= last_hs;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            len_error <= 1'b0;
                            k_len     <= msg_len;
                            cnt       <= '0;
                        end else begin
                            len_error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        cnt       <= last_data ? 8'd0 : cnt + 8'd1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                PARITY: begin
                    if (par_load) begin
                        out_data  <= r[NSYM-1];
                        out_valid <= 1'b1;
                        out_last  <= (cnt == NSYM_L - 8'd1);
                        cnt       <= cnt + 8'd1;
                    end else if (last_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- LFSR stages ----------------
`ifdef RS_ENCODER_PARITY_FLAT_EN
    logic [SYM_W-1:0] r_nxt [NSYM];
`endif

    for (genvar i = 0; i < NSYM; i++) begin : g_cell
        logic [SYM_W-1:0] prev;
        if (i == 0) begin : g_first
            assign prev = '0;
        end else begin : g_rest
            assign prev = r[i-1];
        end

        rs_lfsr_cell u_cell (
            .clk              (clk),
            .rst              (rst),
            .reduction_matrix (reduction_matrix),
            .coef             (generator_flat[SYM_W*i +: SYM_W]),
            .fb               (fb),
            .prev             (prev),
            .clear            (lfsr_clear),
            .feed             (accept),
            .shift            (par_load),
            .q                (r[i])
`ifdef RS_ENCODER_PARITY_FLAT_EN
            ,
            .nxt_feed         (r_nxt[i])
`endif
        );
    end

`ifdef RS_ENCODER_PARITY_FLAT_EN
    // Snapshot the final remainder as it is written on the last data symbol.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_flat <= '0;
        end else if (lfsr_clear) begin
            parity_flat <= '0;
        end else if (last_data) begin
            for (int i = 0; i < NSYM; i++) begin
                parity_flat[SYM_W*i +: SYM_W] <= r_nxt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_encoder.sv
`timescale 1ns/1ps
module tb_rs_encoder;
    import rs_encoder_pkg::*;

    localparam int NSYM    = 2;
    localparam int MAX_LEN = 255;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [RED_W-1:0]      reduction_matrix;
    logic [SYM_W*NSYM-1:0] generator_flat;
    logic [7:0]            msg_len;
    logic                  start;
    logic                  busy;
    logic                  len_error;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  done;
`ifdef RS_ENCODER_PARITY_FLAT_EN
    logic [SYM_W*NSYM-1:0] parity_flat;
`endif

    always #5 clk = ~clk;

    rs_encoder #(.NSYM(NSYM), .MAX_LEN(MAX_LEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .reduction_matrix (reduction_matrix),
        .generator_flat   (generator_flat),
        .msg_len          (msg_len),
        .start            (start),
        .busy             (busy),
        .len_error        (len_error),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .done             (done)
`ifdef RS_ENCODER_PARITY_FLAT_EN
        ,
        .parity_flat      (parity_flat)
`endif
    );

    int         errs;
    int         checks;
    logic [7:0] gen  [0:NSYM-1];
    logic [7:0] msg  [0:255];
    logic [7:0] expv [0:259];

    typedef struct packed {
        logic [7:0]  k;
        logic [1:0]  mode;
        logic [15:0] m;   // message symbols, first symbol in the top byte
        logic [31:0] e;   // expected codeword, first symbol in the top byte
    } vec_t;

    vec_t tbl [0:3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(2^8) multiply, polynomial 0x11D, by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Row j = x^(8+j) mod p(x), p given by its low 8 bits.
    function automatic logic [RED_W-1:0] red_mat(input logic [7:0] plow);
        logic [7:0]       v;
        logic [RED_W-1:0] m;
        m = '0;
        v = plow;
        for (int j = 0; j < 7; j++) begin
            m[8*j +: 8] = v;
            v = v[7] ? ({v[6:0], 1'b0} ^ plow) : {v[6:0], 1'b0};
        end
        return m;
    endfunction

    task automatic set_gen(input logic [7:0] g0, input logic [7:0] g1);
        gen[0] = g0;
        gen[1] = g1;
        for (int i = 0; i < NSYM; i++) generator_flat[8*i +: 8] = gen[i];
    endtask

    // Codeword = message followed by remainder of m(x)*x^NSYM / g(x), by long division.
    task automatic build_expected(input int k);
        logic [7:0] c [0:259];
        logic [7:0] coef;
        for (int i = 0; i < k; i++) c[i] = msg[i];
        for (int i = 0; i < NSYM; i++) c[k+i] = 8'h00;
        for (int i = 0; i < k; i++) begin
            coef = c[i];
            for (int j = 1; j <= NSYM; j++) c[i+j] = c[i+j] ^ gmul(coef, gen[NSYM-j]);
        end
        for (int i = 0; i < k; i++) expv[i] = msg[i];
        for (int i = 0; i < NSYM; i++) expv[k+i] = c[k+i];
    endtask

    // mode 0: out_ready=1; mode 1: out_ready 1,0,0 repeating; mode 2: random valid/ready + stray starts.
    task automatic encode(input int k, input int mode);
        int         idx, oidx, total, cyc, budget;
        logic       stall;
        logic [7:0] hold_dat;
        logic       hold_last;
        idx = 0; oidx = 0; total = k + NSYM; cyc = 0; budget = 40 * total + 100;
        stall = 1'b0; hold_dat = 8'h00; hold_last = 1'b0;
        @(posedge clk); #1;
        msg_len = 8'(k); start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("len_error_after_legal_start", len_error, 0);
        while (oidx < total && cyc < budget) begin
            if (idx < k) begin
                in_data  = msg[idx];
                in_valid = (mode == 2) ? 1'($urandom % 4 != 0) : 1'b1;
            end else begin
                in_data  = 8'($urandom);
                in_valid = 1'($urandom % 2);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom % 3 != 0);
            endcase
            if (mode == 2) begin
                start   = 1'($urandom % 8 == 0);
                msg_len = 8'($urandom);
            end
            #4;
            if (stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, hold_dat);
                check("stall_hold_last", out_last, hold_last);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (idx >= k) check("in_ready_after_msg", in_ready, 0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                check("out_data", out_data, expv[oidx]);
                check("out_last", out_last, (oidx == total - 1));
                oidx++;
            end
            stall     = out_valid && !out_ready;
            hold_dat  = out_data;
            hold_last = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("codeword_complete", oidx, total);
        #4;
        check("done_pulse", done, 1);
        check("busy_clear", busy, 0);
        check("out_valid_clear", out_valid, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int k;
        errs = 0; checks = 0;
        rst = 1'b1; start = 1'b0; msg_len = 8'd0; in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        reduction_matrix = red_mat(8'h1D);
        set_gen(8'h02, 8'h03);

        // Asynchronous reset state
        #1 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_len_error", len_error, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Illegal lengths: 0 and 254 (> MAX_LEN-NSYM = 253)
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            msg_len = (t == 0) ? 8'd0 : 8'd254;
            start = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            #4;
            check("illegal_len_error", len_error, 1);
            check("illegal_busy", busy, 0);
            check("illegal_in_ready", in_ready, 0);
            check("illegal_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        // Directed vectors, g(x) = x^2 + 3x + 2
        tbl[0] = '{k: 8'd1, mode: 2'd0, m: 16'h0100, e: 32'h01030200};
        tbl[1] = '{k: 8'd2, mode: 2'd0, m: 16'h0100, e: 32'h01000706};
        tbl[2] = '{k: 8'd2, mode: 2'd0, m: 16'h0000, e: 32'h00000000};
        tbl[3] = '{k: 8'd2, mode: 2'd1, m: 16'h0100, e: 32'h01000706};
        for (int v = 0; v < 4; v++) begin
            set_gen(8'h02, 8'h03);
            msg[0] = tbl[v].m[15:8];
            msg[1] = tbl[v].m[7:0];
            for (int i = 0; i < int'(tbl[v].k) + NSYM; i++) expv[i] = tbl[v].e[31-8*i -: 8];
            encode(int'(tbl[v].k), int'(tbl[v].mode));
        end

        // Reset asserted mid-DATA aborts at once
        @(posedge clk); #1;
        msg_len = 8'd5; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        check("pre_reset_out_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;

        // Random generators and messages against the division model
        for (int n = 0; n < 12; n++) begin
            set_gen(8'($urandom), 8'($urandom));
            k = $urandom_range(20, 1);
            for (int i = 0; i < k; i++) msg[i] = 8'($urandom);
            build_expected(k);
            encode(k, 2);
        end

        // Longest legal message
        set_gen(8'h02, 8'h03);
        for (int i = 0; i < 253; i++) msg[i] = 8'($urandom);
        build_expected(253);
        encode(253, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
